// File: rtl/seg7_pair_reader.sv
// seg7_pair_reader
//   Reads back a 14-bit active-low two-digit 7-segment bus, debounces it and
//   delivers each new stable legal value on a valid/ready output.
//
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     seg_in[0:13]       segment bus, active-low; [0:6] units a..g, [7:13] tens a..g
//     out_valid/ready    output handshake
//     out_bcd[7:0]       {tens, units} BCD
//     out_bin[6:0]       same value in binary, 0..99
//     err                one-cycle pulse on a stable illegal pattern
//     ovr, ovr_clr       sticky overrun flag and its synchronous clear
//
//   Build option: LEADING_BLANK_EN -- a blank tens field decodes as 0.
module seg7_pair_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:13] seg_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_bcd,
  output logic [6:0]  out_bin,
  output logic        err,
  output logic        ovr,
  input  logic        ovr_clr
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2
  } state_t;

  // {legal, digit}; glyph bits ordered a..g from MSB to LSB
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    logic [4:0] r;
    case (g)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001111: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0000100: r = 5'h19;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  logic [0:13] sync1_q, sync2_q;
  logic [0:13] prev_q, prev_d;
  logic [7:0]  cnt_q, cnt_d;
  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [7:0]  bcd_q;
  logic [6:0]  bin_q;
  logic        err_q, err_d;
  logic        ovr_q;
  logic [7:0]  last_q;
  logic        has_last_q;

  logic        changed, comp, active;
  logic [6:0]  units_pat, tens_pat;
  logic [4:0]  units_dec, tens_dec;
  logic        legal;
  logic [7:0]  dec_bcd;
  logic [6:0]  dec_bin;
  logic        cand, hs, load, ovr_set;

  // Sample tracking, independent of FSM state
  always_comb begin
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    comp    = 1'b0;
    changed = (sync2_q != prev_q);
    if (changed) begin
      prev_d = sync2_q;
      cnt_d  = 8'd1;
      comp   = (STABLE == 8'd1);
    end else if (cnt_q < STABLE) begin
      cnt_d = cnt_q + 8'd1;
      comp  = (cnt_d == STABLE);
    end
  end

  // Completion refers to the pattern being counted, i.e. prev after update
  always_comb begin
    units_pat = prev_d[0:6];
    tens_pat  = prev_d[7:13];
    units_dec = decode_glyph(units_pat);
    tens_dec  = decode_glyph(tens_pat);
`ifdef LEADING_BLANK_EN
    if (tens_pat == 7'b1111111) begin
      tens_dec = 5'h10;
    end
`endif
    legal   = units_dec[4] & tens_dec[4];
    dec_bcd = {tens_dec[3:0], units_dec[3:0]};
    dec_bin = ({3'b000, tens_dec[3:0]} << 3) + ({3'b000, tens_dec[3:0]} << 1)
              + {3'b000, units_dec[3:0]};
  end

  // IDLE only acts on a completion coinciding with a change (STABLE_CYCLES = 1);
  // this keeps the post-reset count-up of the idle bus from raising err.
  assign active = (state_q != IDLE) || changed;
  assign cand   = comp && active && legal && (!has_last_q || (dec_bcd != last_q));
  assign hs     = valid_q && out_ready;
  assign err_d  = comp && active && !legal;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    load    = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (cand) begin
          load    = 1'b1;
          valid_d = 1'b1;
          state_d = EMIT;
        end else if (comp) begin
          state_d = IDLE;
        end else if (changed) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cand) begin
          load    = 1'b1;
          valid_d = 1'b1;
          state_d = EMIT;
        end else if (comp) begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (cand && hs) begin
          load = 1'b1;
        end else if (cand) begin
          ovr_set = 1'b1;
        end else if (hs) begin
          valid_d = 1'b0;
          state_d = (cnt_d < STABLE) ? SETTLE : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      prev_q     <= '1;
      cnt_q      <= '0;
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      bcd_q      <= '0;
      bin_q      <= '0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      last_q     <= '0;
      has_last_q <= 1'b0;
    end else begin
      sync1_q <= seg_in;
      sync2_q <= sync1_q;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      if (load) begin
        bcd_q      <= dec_bcd;
        bin_q      <= dec_bin;
        last_q     <= dec_bcd;
        has_last_q <= 1'b1;
      end
      if (ovr_set) begin
        ovr_q <= 1'b1;
      end else if (ovr_clr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_bcd   = bcd_q;
  assign out_bin   = bin_q;
  assign err       = err_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_seg7_pair_reader.sv
module tb_seg7_pair_reader;

  localparam logic [6:0] G0 = 7'b0000001;
  localparam logic [6:0] G1 = 7'b1001111;
  localparam logic [6:0] G2 = 7'b0010010;
  localparam logic [6:0] G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100;
  localparam logic [6:0] G5 = 7'b0100100;
  localparam logic [6:0] G6 = 7'b0100000;
  localparam logic [6:0] G7 = 7'b0001111;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0000100;
  localparam logic [6:0] GB = 7'b1111111;
  localparam logic [6:0] GX = 7'b1110000;

  logic        clk;
  logic        rst_n;
  logic [0:13] seg_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_bcd;
  logic [6:0]  out_bin;
  logic        err;
  logic        ovr;
  logic        ovr_clr;

  seg7_pair_reader #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_bin   (out_bin),
    .err       (err),
    .ovr       (ovr),
    .ovr_clr   (ovr_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [6:0] tens;
    logic [6:0] units;
    bit         legal;
    logic [7:0] bcd;
    logic [6:0] bin;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;
  int err_seen = 0;
  int valid_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (err) err_seen++;
    if (out_valid) valid_seen++;
  endtask

  task automatic set_seg(input logic [6:0] tens, input logic [6:0] units);
    seg_in[0:6]  = units;
    seg_in[7:13] = tens;
  endtask

  // Edges until out_valid or err appears; 21 means it never did
  task automatic wait_event(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(out_valid || err) && n < 21);
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int n;
    out_ready  = 1'b0;
    set_seg(v.tens, v.units);
    err_seen   = 0;
    valid_seen = 0;
    wait_event(n);
    check({tag, " latency"}, n, 6);
    if (v.legal) begin
      check({tag, " valid"}, out_valid, 1'b1);
      check({tag, " no err"}, err, 1'b0);
      check({tag, " bcd"}, out_bcd, v.bcd);
      check({tag, " bin"}, out_bin, v.bin);
      out_ready = 1'b1;
      step();
      check({tag, " valid drop"}, out_valid, 1'b0);
      out_ready = 1'b0;
    end else begin
      check({tag, " err"}, err, 1'b1);
      check({tag, " no valid"}, out_valid, 1'b0);
      step();
      check({tag, " err single"}, err, 1'b0);
      repeat (3) step();
      check({tag, " never valid"}, valid_seen, 0);
    end
  endtask

  vec_t tbl[10];
  vec_t v;
  int   n;

  initial begin
    tbl[0] = '{G5, G7, 1'b1, 8'h57, 7'd57};
    tbl[1] = '{G0, G0, 1'b1, 8'h00, 7'd0};
    tbl[2] = '{G9, G9, 1'b1, 8'h99, 7'd99};
    tbl[3] = '{G3, GB, 1'b0, 8'h00, 7'd0};
    tbl[4] = '{G1, G0, 1'b1, 8'h10, 7'd10};
    tbl[5] = '{G8, G3, 1'b1, 8'h83, 7'd83};
    tbl[6] = '{GX, G2, 1'b0, 8'h00, 7'd0};
    tbl[7] = '{G3, G6, 1'b1, 8'h36, 7'd36};
    tbl[8] = '{G0, G9, 1'b1, 8'h09, 7'd9};
    tbl[9] = '{G7, G5, 1'b1, 8'h75, 7'd75};

    rst_n     = 1'b1;
    seg_in    = '1;
    out_ready = 1'b0;
    ovr_clr   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset valid", out_valid, 1'b0);
    check("reset bcd", out_bcd, 8'h00);
    check("reset bin", out_bin, 7'd0);
    check("reset err", err, 1'b0);
    check("reset ovr", ovr, 1'b0);
    step();
    step();
    rst_n = 1'b1;

    // First value, then no re-emit while held
    v = '{G4, G2, 1'b1, 8'h42, 7'd42};
    apply_vec(v, "t1_42");
    valid_seen = 0;
    repeat (10) step();
    check("t1 no re-emit", valid_seen, 0);

    // Short units glitch to 41 and back to the already emitted 42
    err_seen   = 0;
    valid_seen = 0;
    set_seg(G4, G1);
    step();
    step();
    set_seg(G4, G2);
    repeat (14) step();
    check("t2 glitch no valid", valid_seen, 0);
    check("t2 glitch no err", err_seen, 0);

    // Blank tens
`ifdef LEADING_BLANK_EN
    v = '{GB, G0, 1'b1, 8'h00, 7'd0};
`else
    v = '{GB, G0, 1'b0, 8'h00, 7'd0};
`endif
    apply_vec(v, "t3_blank");
    check("t3 err count", err_seen, `ifdef LEADING_BLANK_EN 0 `else 1 `endif);

    for (int i = 0; i < 10; i++) begin
      apply_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Overrun: 42 pending, 57 completes without handshake
    out_ready = 1'b0;
    set_seg(G4, G2);
    wait_event(n);
    check("t4 latency", n, 6);
    check("t4 bcd42", out_bcd, 8'h42);
    set_seg(G5, G7);
    repeat (8) step();
    check("t4 ovr set", ovr, 1'b1);
    check("t4 valid held", out_valid, 1'b1);
    check("t4 bcd frozen", out_bcd, 8'h42);
    check("t4 bin frozen", out_bin, 7'd42);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t4 valid drop", out_valid, 1'b0);
    check("t4 ovr sticky", ovr, 1'b1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("t4 ovr clr", ovr, 1'b0);

    // Asynchronous reset while a value is pending and ovr is set
    set_seg(G6, G1);
    wait_event(n);
    check("t6 valid61", out_valid, 1'b1);
    set_seg(G4, G2);
    repeat (8) step();
    check("t6 ovr set", ovr, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6 async valid", out_valid, 1'b0);
    check("t6 async bcd", out_bcd, 8'h00);
    check("t6 async bin", out_bin, 7'd0);
    check("t6 async err", err, 1'b0);
    check("t6 async ovr", ovr, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Completion of 57 coincides with the handshake of 42
    wait_event(n);
    check("t5 latency", n, 6);
    check("t5 bcd42", out_bcd, 8'h42);
    set_seg(G5, G7);
    valid_seen = 0;
    repeat (5) step();
    check("t5 valid held", valid_seen, 5);
    check("t5 bcd still 42", out_bcd, 8'h42);
    out_ready = 1'b1;
    step();
    check("t5 valid stays", out_valid, 1'b1);
    check("t5 bcd57", out_bcd, 8'h57);
    check("t5 bin57", out_bin, 7'd57);
    check("t5 no ovr", ovr, 1'b0);
    step();
    check("t5 valid drop", out_valid, 1'b0);
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
